// File: rtl/ff_input_ctl_if.sv
// ff_input_ctl_if: switch and auto-play signal bundle between a board top and ff_input_ctl.
interface ff_input_ctl_if #(
    parameter int NUM_SW = 8
);
    logic [NUM_SW-1:0] sw_raw_n;
    logic [1:0]        auto_mode;
    logic              auto_go;
    logic [NUM_SW-1:0] sw_n;
    logic              auto_coin_n;
    logic              auto_start_n;
    logic              auto_throw_n;
    logic              busy;
    modport master (
        output sw_raw_n, auto_mode, auto_go,
        input  sw_n, auto_coin_n, auto_start_n, auto_throw_n, busy
    );
    modport slave (
        input  sw_raw_n, auto_mode, auto_go,
        output sw_n, auto_coin_n, auto_start_n, auto_throw_n, busy
    );
endinterface

// File: rtl/ff_input_ctl.sv
// ff_input_ctl: per-bit debounce of active-low buttons merged with an auto-play
// coin/start/throw sequencer into a registered active-low switch bus.
module ff_input_ctl #(
    parameter int NUM_SW    = 8,
    parameter int DEB_COUNT = 16'd60000,
    parameter int DEB_BITS  = 16,
    parameter int TICK_DIV  = 12000,
    parameter int PRESS_MS  = 100,
    parameter int GAP_MS    = 500,
    parameter int COIN_IDX  = 5,
    parameter int START_IDX = 3,
    parameter int THROW_IDX = 1
) (
    input logic           clk12m,
    input logic           reset,
    ff_input_ctl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_COIN, S_GAP1, S_START, S_GAP2, S_THROW, S_GAP3} state_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2((PRESS_MS > GAP_MS ? PRESS_MS : GAP_MS) + 1);
    localparam logic [PW-1:0]       PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]       PRESS_LAST = TW'(PRESS_MS - 1);
    localparam logic [TW-1:0]       GAP_LAST   = TW'(GAP_MS - 1);
    localparam logic [DEB_BITS-1:0] DEB_LAST   = DEB_BITS'(DEB_COUNT - 1);
    state_t               r_state, w_next;
    logic [PW-1:0]        r_pre;
    logic [TW-1:0]        r_tmr;
    logic                 w_tick, w_done;
    logic [NUM_SW-1:0]    r_sync1, r_sync2, r_deb, r_sw_n, w_mask;
    logic [DEB_BITS-1:0]  r_cnt [NUM_SW];
    logic                 r_coin_n, r_start_n, r_throw_n, r_busy;
    assign w_tick = r_pre == PRE_LAST;
    assign w_done = w_tick && r_tmr == ((r_state inside {S_COIN, S_START, S_THROW}) ? PRESS_LAST : GAP_LAST);
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = (bus.auto_mode == 2'b11 || (bus.auto_mode == 2'b01 && bus.auto_go)) ? S_COIN :
                              bus.auto_mode == 2'b10 ? S_THROW : S_IDLE;
            S_COIN:  w_next = w_done ? S_GAP1 : S_COIN;
            S_GAP1:  w_next = w_done ? S_START : S_GAP1;
            S_START: w_next = w_done ? S_GAP2 : S_START;
            S_GAP2:  w_next = w_done ? S_THROW : S_GAP2;
            S_THROW: w_next = w_done ? S_GAP3 : S_THROW;
            S_GAP3:  w_next = !w_done ? S_GAP3 : bus.auto_mode == 2'b10 ? S_THROW : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.auto_mode == 2'b00)
            w_next = S_IDLE;
    end
    // auto presses follow the next state so sw_n moves on the same edge as the state
    always_comb begin
        w_mask            = '1;
        w_mask[COIN_IDX]  = w_next != S_COIN;
        w_mask[START_IDX] = w_next != S_START;
        w_mask[THROW_IDX] = w_next != S_THROW;
    end
    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_coin_n  <= 1'b1;
            r_start_n <= 1'b1;
            r_throw_n <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_coin_n  <= w_next != S_COIN;
            r_start_n <= w_next != S_START;
            r_throw_n <= w_next != S_THROW;
            r_busy    <= w_next != S_IDLE;
        end
    end
    always_ff @(posedge clk12m) begin
        if (reset || w_next != r_state || r_state == S_IDLE) begin
            r_pre <= '0;
            r_tmr <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            r_tmr <= r_tmr + TW'(w_tick);
        end
    end
    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_sw_n  <= '1;
            for (int i = 0; i < NUM_SW; i++)
                r_cnt[i] <= '0;
        end else begin
            r_sync1 <= bus.sw_raw_n;
            r_sync2 <= r_sync1;
            r_sw_n  <= r_deb & w_mask;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= (r_sync2[i] == r_deb[i] || r_cnt[i] == DEB_LAST) ? '0 : r_cnt[i] + 1'b1;
                if (r_sync2[i] != r_deb[i] && r_cnt[i] == DEB_LAST)
                    r_deb[i] <= r_sync2[i];
            end
        end
    end
    assign bus.sw_n         = r_sw_n;
    assign bus.auto_coin_n  = r_coin_n;
    assign bus.auto_start_n = r_start_n;
    assign bus.auto_throw_n = r_throw_n;
    assign bus.busy         = r_busy;
endmodule

// File: doc/ff_input_ctl.md
# ff_input_ctl

Parametrised player-input conditioner for the foodfight board tops. It debounces `NUM_SW` raw active-low buttons and runs an auto-play sequencer that generates coin, start and throw presses. The debounced and auto-play signals are merged into a registered, active-low switch bus that feeds the game core's `sw` input. It replaces the fixed auto_coin_n/auto_start_n/auto_throw_n generation in the clock-and-reset block. Unlike that logic, it has selectable modes, programmable timing and per-bit debounce.

## Interface
- `NUM_SW`, 8: number of switch bits.
- `DEB_COUNT`, 16'd60000: consecutive stable cycles needed to accept a new level (5 ms at 12 MHz). Minimum 1.
- `DEB_BITS`, 16: width of each debounce counter. Must satisfy `DEB_COUNT < 2**DEB_BITS`.
- `TICK_DIV`, 12000: clk12m cycles per sequencer tick (1 ms). Minimum 2.
- `PRESS_MS`, 100: ticks a generated press is held. Minimum 1.
- `GAP_MS`, 500: ticks between generated presses. Minimum 1.
- `COIN_IDX`, 5; `START_IDX`, 3; `THROW_IDX`, 1: which `sw_n` bits the auto presses drive. The three indices must be distinct and less than `NUM_SW`.
- `clk12m`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `sw_raw_n`, in, NUM_SW: raw buttons, active-low, asynchronous to clk12m.
- `auto_mode`, in, 2: 00 = off; 01 = single sequence; 10 = continuous throw; 11 = repeating sequence.
- `auto_go`, in, 1: synchronous one-cycle trigger for mode 01.
- `sw_n`, out, NUM_SW: conditioned switches, active-low, registered.
- `auto_coin_n`, `auto_start_n`, `auto_throw_n`, out, 1 each: raw sequencer presses, active-low, registered.
- `busy`, out, 1: high whenever the sequencer is not in IDLE.

## Operation
- **Synchroniser.** Each `sw_raw_n` bit passes through a two-flop synchroniser.
- **Debounce, per bit.**
  - Each bit keeps a debounced level `deb[i]` and a counter `cnt[i]`.
  - If the synchronised bit equals `deb[i]`, `cnt[i]` is cleared to 0.
  - Otherwise `cnt[i]` increments. On the cycle it would reach `DEB_COUNT`, `deb[i]` takes the new level and `cnt[i]` is cleared.
  - Any glitch shorter than `DEB_COUNT` cycles clears the count and is never seen at the output.
- **Merge.**
  - `sw_n[COIN_IDX] <= deb[COIN_IDX] & auto_coin_n_next`.
  - The START and THROW bits are merged the same way.
  - All other bits: `sw_n[i] <= deb[i]`.
- **Timebase.**
  - A prescaler counts 0..TICK_DIV-1 and asserts `tick` at TICK_DIV-1.
  - The prescaler and a tick counter `tmr` are both zeroed on every state entry. Each state therefore lasts exactly N×TICK_DIV cycles.
- **Sequencer states** (press outputs held low only in the state named):
  - **IDLE.**
    - Mode 01 with `auto_go` high: go to COIN.
    - Mode 11: go to COIN on the next cycle.
    - Mode 10: go to THROW.
    - Mode 00, or mode 01 without `auto_go`: stay.
  - **COIN:** `auto_coin_n`=0 for `PRESS_MS` ticks, then GAP1.
  - **GAP1:** `GAP_MS` ticks, then START.
  - **START:** `auto_start_n`=0 for `PRESS_MS` ticks, then GAP2.
  - **GAP2:** `GAP_MS` ticks, then THROW.
  - **THROW:** `auto_throw_n`=0 for `PRESS_MS` ticks, then GAP3.
  - **GAP3:** `GAP_MS` ticks. Then IDLE in modes 01 and 11; back to THROW in mode 10.
- **Mode changes and triggers.**
  - `auto_go` is ignored outside IDLE and in every mode except 01.
  - If `auto_mode` changes to 00 in any state: IDLE on the next edge, all auto outputs high on that same edge.
  - Any other mode change mid-sequence takes effect only when the decision is made in GAP3 or IDLE.
- **Manual and auto overlap.** A simultaneous manual and auto press on the same bit is a logical AND. The bit stays low while either source is low.

## Timing
- **Reset** (synchronous, one cycle is sufficient), values from the next edge:
  - `deb` and `sw_n` all 1; synchroniser flops 1; counters 0.
  - State IDLE; prescaler and `tmr` 0.
  - `auto_*_n` = 1; `busy` = 0.
- **Reset mid-sequence** aborts immediately to the values above. Reset mid-debounce discards the partial count.
- **Debounce latency.** A raw level held stable is first sampled at edge 0. `sw_n` changes at edge `DEB_COUNT+2`: 2 cycles of synchroniser, `DEB_COUNT` counting edges with the final one also registering `sw_n`.
- **Auto outputs.** `auto_*_n` and `busy` change on the same edge the state register changes. The merged `sw_n` bit changes on that same edge.
- **Trigger latency.** `auto_go` sampled high in IDLE (mode 01) gives `auto_coin_n`=0 and `busy`=1 at the next edge.
- **Press width.** Exactly `PRESS_MS`×`TICK_DIV` cycles. Gaps are exactly `GAP_MS`×`TICK_DIV` cycles.
- **Single-sequence length** (mode 01): 3×PRESS_MS + 3×GAP_MS ticks from leaving IDLE to re-entering IDLE.
- **Counter wrap.** `tmr` never wraps, because the exit fires at the terminal count. The prescaler wraps from TICK_DIV-1 to 0.

## Test plan
All scenarios use `TICK_DIV`=4, `PRESS_MS`=2, `GAP_MS`=3, `DEB_COUNT`=4, `NUM_SW`=8.

1. **Reset.** Hold `reset` for 1 cycle with all inputs at X→1. Required: `sw_n`=8'hFF, auto outputs 1, `busy`=0 on the next edge.
2. **Debounce accept and reject.**
   - Drive `sw_raw_n[0]` low and hold. Required: `sw_n[0]`=0 exactly 6 edges later.
   - Drive a low pulse of 3 cycles. Required: `sw_n[0]` stays 1.
3. **Single sequence.** Mode 01, pulse `auto_go`. Required:
   - `auto_coin_n` low for 8 cycles, high for 12.
   - `auto_start_n` low for 8, high for 12.
   - `auto_throw_n` low for 8, then 12 more cycles before IDLE.
   - `busy` high for exactly 60 cycles.
   - `sw_n[5]`, `sw_n[3]` and `sw_n[1]` mirror the presses.
   - A second `auto_go` while busy is ignored.
4. **Continuous throw.** Mode 10 for 100 cycles. Required: `auto_throw_n` is low 8 / high 12 periodically, and coin/start stay 1.
5. **Abort.**
   - Switch mode 11→00 during START. Required: state IDLE, `auto_start_n`=1, `busy`=0 on the next edge.
   - Separately, assert `reset` during THROW. Required: the reset values on the next edge.
6. **Merge.** Hold `sw_raw_n[1]` low while the sequencer is in GAP3. Required: `sw_n[1]`=0 throughout. When the auto throw ends while the manual press is still held, `sw_n[1]` stays 0.
